hash_probe: RTL and testbench

- Consumer end of the hash pipeline: takes key_out/table_index/ctr_out from the hash block and resolves each key against the hash table in memory by linear probing.
- Back-pressures the hash block through its stall input.
- Reports hit, miss (with first empty slot for insert) or table-full per key to downstream logic.
- One key in flight at a time; one outstanding memory read at a time.

---
 rtl/hash_probe_if.sv | 45 ++++
 rtl/hash_probe.sv | 152 +++++++++++++++
 tb/tb_hash_probe.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hash_probe_if.sv
// Bus bundle between hash_probe and its neighbours: hash-block input, table memory port, result port.
// The probe block uses the slave modport; the surrounding pipeline or bench drives the master side.
interface hash_probe_if #(
    parameter int unsigned KEY_W = 200
);
    // hash block side
    logic [KEY_W-1:0] key;
    logic [31:0]      table_index;
    logic [1:0]       ctr_in;
    logic [31:0]      table_size;
    logic             stall;

    // table memory side
    logic             mem_rd_en;
    logic [31:0]      mem_rd_addr;
    logic             mem_busy;
    logic             mem_rsp_valid;
    logic             mem_rsp_occupied;
    logic [KEY_W-1:0] mem_rsp_key;

    // result side
    logic             res_valid;
    logic             res_stall;
    logic [KEY_W-1:0] res_key;
    logic [31:0]      res_index;
    logic [1:0]       res_ctr;
    logic             res_hit;
    logic             res_full;

    modport slave (
        input  key, table_index, ctr_in, table_size,
        input  mem_busy, mem_rsp_valid, mem_rsp_occupied, mem_rsp_key,
        input  res_stall,
        output stall, mem_rd_en, mem_rd_addr,
        output res_valid, res_key, res_index, res_ctr, res_hit, res_full
    );

    modport master (
        output key, table_index, ctr_in, table_size,
        output mem_busy, mem_rsp_valid, mem_rsp_occupied, mem_rsp_key,
        output res_stall,
        input  stall, mem_rd_en, mem_rd_addr,
        input  res_valid, res_key, res_index, res_ctr, res_hit, res_full
    );
endinterface

// File: rtl/hash_probe.sv
// Resolves one key at a time against the in-memory hash table by linear probing: hit, miss or full.
// Optional counters stat_keys/stat_hits/stat_full/stat_probes exist only when HASH_PROBE_STATS_EN is defined.
module hash_probe #(
    parameter int unsigned MAX_PROBES = 16,
    parameter int unsigned KEY_W      = 200
) (
    input  logic        clk,
    input  logic        rst,
    hash_probe_if.slave bus
`ifdef HASH_PROBE_STATS_EN
    ,
    output logic [31:0] stat_keys,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_full,
    output logic [47:0] stat_probes
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [16:0] MAX_P = 17'(MAX_PROBES);

    state_t      state;
    logic [31:0] cur_idx;
    logic [16:0] cnt;

    logic        accept;
    logic        rd_req;
    logic        rsp_seen;
    logic        key_match;
    logic        limit_hit;
    logic        terminal;
    logic        finish;
    logic [16:0] cnt_next;
    logic [31:0] idx_inc;
    logic [31:0] idx_wrap;

    // res_key/res_ctr double as the captured key and tag for the whole lookup.
    assign accept    = (state == S_IDLE) && (bus.ctr_in != 2'd0);
    assign rd_req    = (state == S_REQ) && !bus.mem_busy;
    assign rsp_seen  = (state == S_WAIT) && bus.mem_rsp_valid;
    assign key_match = bus.mem_rsp_occupied && (bus.mem_rsp_key == bus.res_key);
    assign cnt_next  = cnt + 17'd1;
    assign limit_hit = (cnt_next == MAX_P) || ({15'd0, cnt_next} == bus.table_size);
    assign terminal  = !bus.mem_rsp_occupied || key_match || limit_hit;
    assign finish    = rsp_seen && terminal;
    assign idx_inc   = cur_idx + 32'd1;
    assign idx_wrap  = (idx_inc == bus.table_size) ? 32'd0 : idx_inc;

    // The hash block must see back-pressure in the same cycle a key is taken.
    assign bus.stall       = (state != S_IDLE) || (bus.ctr_in != 2'd0);
    assign bus.mem_rd_en   = rd_req;
    assign bus.mem_rd_addr = cur_idx;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            cur_idx       <= '0;
            cnt           <= '0;
            bus.res_valid <= 1'b0;
            bus.res_key   <= '0;
            bus.res_index <= '0;
            bus.res_ctr   <= '0;
            bus.res_hit   <= 1'b0;
            bus.res_full  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        bus.res_key  <= bus.key;
                        bus.res_ctr  <= bus.ctr_in;
                        bus.res_hit  <= 1'b0;
                        bus.res_full <= 1'b0;
                        cur_idx      <= bus.table_index;
                        cnt          <= '0;
                        state        <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (rd_req) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (rsp_seen) begin
                        cnt <= cnt_next;
                        if (terminal) begin
                            bus.res_valid <= 1'b1;
                            bus.res_index <= cur_idx;
                            bus.res_hit   <= key_match;
                            bus.res_full  <= bus.mem_rsp_occupied && !key_match;
                            state         <= S_DONE;
                        end else begin
                            cur_idx <= idx_wrap;
                            state   <= S_REQ;
                        end
                    end
                end
                S_DONE: begin
                    if (!bus.res_stall) begin
                        bus.res_valid <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef HASH_PROBE_STATS_EN
    function automatic logic [31:0] sat32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [47:0] sat48(input logic [47:0] v);
        return (&v) ? v : v + 48'd1;
    endfunction

    // Counters saturate rather than wrap so a long run never reports a small value.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_keys   <= '0;
            stat_hits   <= '0;
            stat_full   <= '0;
            stat_probes <= '0;
        end else begin
            if (accept) begin
                stat_keys <= sat32(stat_keys);
            end
            if (finish && key_match) begin
                stat_hits <= sat32(stat_hits);
            end
            if (finish && bus.mem_rsp_occupied && !key_match) begin
                stat_full <= sat32(stat_full);
            end
            if (rd_req) begin
                stat_probes <= sat48(stat_probes);
            end
        end
    end
`else
    logic unused_finish;
    assign unused_finish = finish;
`endif

endmodule

// File: tb/tb_hash_probe.sv
// Self-checking bench for hash_probe: table vectors, hand-written corner sequences and random keys
// checked against a modulo-arithmetic linear-probing model over a bench-side table image.
module tb_hash_probe;

    localparam int KEY_W      = 200;
    localparam int MAX_PROBES = 16;
    localparam int TMAX       = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hash_probe_if #(.KEY_W(KEY_W)) bus ();

`ifdef HASH_PROBE_STATS_EN
    logic [31:0] stat_keys, stat_hits, stat_full;
    logic [47:0] stat_probes;
`endif

    hash_probe #(
        .MAX_PROBES(MAX_PROBES),
        .KEY_W     (KEY_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
`ifdef HASH_PROBE_STATS_EN
        ,
        .stat_keys  (stat_keys),
        .stat_hits  (stat_hits),
        .stat_full  (stat_full),
        .stat_probes(stat_probes)
`endif
    );

    int checks = 0;
    int errors = 0;

    // table image seen by the memory responder and by the reference model
    bit               occ[TMAX];
    logic [KEY_W-1:0] slot_key[TMAX];
    int               exp_addrs[$];
    int               pend_addr[$];
    int               pend_due[$];
    int               t_keys, t_hits, t_full, t_probes;

    typedef struct {
        int          tsize;
        logic [63:0] mask;
        int          match;
        int          idx;
        logic [1:0]  ctr;
        int          lat;
        int          busy;
        int          rstall;
        bit          e_hit;
        bit          e_full;
        int          e_index;
        int          e_n;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [KEY_W-1:0] mk_key(input int unsigned id);
        logic [31:0] a;
        a = id * 32'h9E3779B1;
        return {id, a, ~a, a ^ 32'h5A5A5A5A, id + 32'd13, a + id, id[7:0]};
    endfunction

    function automatic void setup_table(input logic [63:0] mask, input int match, input logic [KEY_W-1:0] k);
        for (int i = 0; i < TMAX; i++) begin
            occ[i]      = mask[i];
            slot_key[i] = mk_key(32'(1000 + i));
        end
        if (match >= 0) begin
            occ[match]      = 1'b1;
            slot_key[match] = k;
        end
    endfunction

    // Probe sequence is (idx + p) mod tsize for p below min(tsize, MAX_PROBES).
    function automatic void model(input logic [KEY_W-1:0] k, input int idx, input int tsize,
                                  output bit hit, output bit full, output int index);
        int limit;
        int a;
        limit = (tsize < MAX_PROBES) ? tsize : MAX_PROBES;
        exp_addrs.delete();
        hit   = 1'b0;
        full  = 1'b0;
        index = 0;
        for (int p = 0; p < limit; p++) begin
            a = (idx + p) % tsize;
            exp_addrs.push_back(a);
            index = a;
            if (!occ[a]) return;
            if (slot_key[a] == k) begin
                hit = 1'b1;
                return;
            end
        end
        full = 1'b1;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, " stall"},       KEY_W'(bus.stall),       '0);
        check({tag, " mem_rd_en"},   KEY_W'(bus.mem_rd_en),   '0);
        check({tag, " mem_rd_addr"}, KEY_W'(bus.mem_rd_addr), '0);
        check({tag, " res_valid"},   KEY_W'(bus.res_valid),   '0);
        check({tag, " res_key"},     bus.res_key,             '0);
        check({tag, " res_index"},   KEY_W'(bus.res_index),   '0);
        check({tag, " res_ctr"},     KEY_W'(bus.res_ctr),     '0);
        check({tag, " res_hit"},     KEY_W'(bus.res_hit),     '0);
        check({tag, " res_full"},    KEY_W'(bus.res_full),    '0);
    endtask

    // Presents one key, services the memory with fixed latency, and checks the whole lookup.
    task automatic run_key(input string tag, input logic [KEY_W-1:0] k, input logic [1:0] ctr,
                           input int idx, input int tsize, input int lat, input int busy, input int rstall,
                           output bit o_hit, output bit o_full, output int o_index, output int o_n);
        bit               e_hit, e_full;
        int               e_index, c, a, hold, done_cyc;
        bit               done, stall_ok, busy_rd, stable;
        int               got[$];
        logic [KEY_W-1:0] r_key;
        logic [31:0]      r_index;
        logic [1:0]       r_ctr;
        logic             r_hit, r_full;

        model(k, idx, tsize, e_hit, e_full, e_index);
        done = 0; stall_ok = 1; busy_rd = 0; stable = 1; hold = 0; done_cyc = -1;
        r_key = '0; r_index = '0; r_ctr = '0; r_hit = 0; r_full = 0;
        pend_addr.delete();
        pend_due.delete();

        @(negedge clk);
        bus.key = k; bus.ctr_in = ctr; bus.table_index = 32'(idx); bus.table_size = 32'(tsize);
        bus.mem_busy = 0; bus.mem_rsp_valid = 0; bus.res_stall = 0;
        #1;
        check({tag, " accept stall"}, KEY_W'(bus.stall), KEY_W'(1));

        c = 0;
        while (!done && c < 1000) begin
            @(posedge clk);
            @(negedge clk);
            c++;
            bus.ctr_in      = 2'($urandom_range(0, 3));
            bus.key         = ~k;
            bus.table_index = $urandom;
            bus.mem_busy    = (c <= busy);
            if (pend_due.size() > 0 && pend_due[0] == c) begin
                a = pend_addr.pop_front();
                void'(pend_due.pop_front());
                bus.mem_rsp_valid    = 1'b1;
                bus.mem_rsp_occupied = (a >= 0 && a < TMAX) ? occ[a] : 1'b0;
                bus.mem_rsp_key      = (a >= 0 && a < TMAX) ? slot_key[a] : '0;
            end else begin
                bus.mem_rsp_valid    = 1'b0;
                bus.mem_rsp_occupied = 1'($urandom);
                bus.mem_rsp_key      = k;
            end
            #1;
            if (!bus.stall) stall_ok = 0;
            if (bus.mem_rd_en) begin
                if (bus.mem_busy) busy_rd = 1;
                got.push_back(int'(bus.mem_rd_addr));
                pend_addr.push_back(int'(bus.mem_rd_addr));
                pend_due.push_back(c + lat);
            end
            if (bus.res_valid) begin
                if (hold == 0) begin
                    done_cyc = c;
                    r_key = bus.res_key; r_index = bus.res_index; r_ctr = bus.res_ctr;
                    r_hit = bus.res_hit; r_full = bus.res_full;
                end else if (bus.res_key !== r_key || bus.res_index !== r_index || bus.res_ctr !== r_ctr ||
                             bus.res_hit !== r_hit || bus.res_full !== r_full) begin
                    stable = 0;
                end
                hold++;
                bus.res_stall = (hold <= rstall);
                if (!bus.res_stall) done = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        bus.ctr_in = 0; bus.mem_rsp_valid = 0; bus.res_stall = 0; bus.mem_busy = 0;
        #1;

        check({tag, " result seen"}, KEY_W'(done), KEY_W'(1));
        check({tag, " stall held"}, KEY_W'(stall_ok), KEY_W'(1));
        check({tag, " read while busy"}, KEY_W'(busy_rd), KEY_W'(0));
        check({tag, " read count"}, KEY_W'(got.size()), KEY_W'(exp_addrs.size()));
        for (int i = 0; i < got.size() && i < exp_addrs.size(); i++)
            check($sformatf("%s read addr %0d", tag, i), KEY_W'(got[i]), KEY_W'(exp_addrs[i]));
        check({tag, " res_hit"}, KEY_W'(r_hit), KEY_W'(e_hit));
        check({tag, " res_full"}, KEY_W'(r_full), KEY_W'(e_full));
        check({tag, " res_index"}, KEY_W'(r_index), KEY_W'(e_index));
        check({tag, " res_key"}, r_key, k);
        check({tag, " res_ctr"}, KEY_W'(r_ctr), KEY_W'(ctr));
        check({tag, " result cycle"}, KEY_W'(done_cyc), KEY_W'(1 + busy + exp_addrs.size() * (1 + lat)));
        check({tag, " hold cycles"}, KEY_W'(hold), KEY_W'(rstall + 1));
        check({tag, " result stable"}, KEY_W'(stable), KEY_W'(1));
        check({tag, " res_valid drops"}, KEY_W'(bus.res_valid), KEY_W'(0));
        check({tag, " stall released"}, KEY_W'(bus.stall), KEY_W'(0));

        t_keys++;
        t_probes += exp_addrs.size();
        t_hits   += int'(e_hit);
        t_full   += int'(e_full);
        o_hit   = r_hit;
        o_full  = r_full;
        o_index = int'(r_index);
        o_n     = got.size();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit               o_hit, o_full;
        int               o_index, o_n, ts, pct, s;
        bit               bad;
        logic [KEY_W-1:0] k;

        //               tsize mask                 match idx ctr lat busy rst  hit full index n
        vecs[0] = '{8,  64'h0,                3,    3,  1,  1,  0,   0,   1,  0,   3,    1};
        vecs[1] = '{8,  64'hC0,               -1,   6,  2,  1,  0,   0,   0,  0,   0,    3};
        vecs[2] = '{4,  64'hF,                -1,   2,  3,  1,  0,   0,   0,  1,   1,    4};
        vecs[3] = '{8,  64'h0,                5,    5,  1,  3,  5,   2,   1,  0,   5,    1};
        vecs[4] = '{5,  64'h1F,               1,    3,  2,  2,  1,   1,   1,  0,   1,    4};
        vecs[5] = '{1,  64'h1,                -1,   0,  1,  1,  0,   0,   0,  1,   0,    1};
        vecs[6] = '{32, 64'hFFFF_FFFF,        -1,   10, 3,  1,  0,   0,   0,  1,   25,   16};
        vecs[7] = '{8,  64'h0,                -1,   4,  1,  2,  2,   0,   0,  0,   4,    1};

        rst = 1'b1;
        bus.key = '0; bus.table_index = '0; bus.ctr_in = '0; bus.table_size = 32'd8;
        bus.mem_busy = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_occupied = 0; bus.mem_rsp_key = '0;
        bus.res_stall = 0;
        t_keys = 0; t_hits = 0; t_full = 0; t_probes = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_values("reset");

        for (int v = 0; v < 8; v++) begin
            k = mk_key(32'(v + 1));
            setup_table(vecs[v].mask, vecs[v].match, k);
            run_key($sformatf("vec%0d", v), k, vecs[v].ctr, vecs[v].idx, vecs[v].tsize,
                    vecs[v].lat, vecs[v].busy, vecs[v].rstall, o_hit, o_full, o_index, o_n);
            check($sformatf("vec%0d table hit", v), KEY_W'(o_hit), KEY_W'(vecs[v].e_hit));
            check($sformatf("vec%0d table full", v), KEY_W'(o_full), KEY_W'(vecs[v].e_full));
            check($sformatf("vec%0d table index", v), KEY_W'(o_index), KEY_W'(vecs[v].e_index));
            check($sformatf("vec%0d table reads", v), KEY_W'(o_n), KEY_W'(vecs[v].e_n));
        end

        // bubbles are ignored: no stall, no read
        bad = 0;
        @(negedge clk);
        bus.ctr_in = 0;
        bus.key    = KEY_W'(8'hFF);
        repeat (4) begin
            #1;
            if (bus.stall || bus.mem_rd_en || bus.res_valid) bad = 1;
            @(negedge clk);
        end
        check("bubble ignored", KEY_W'(bad), KEY_W'(0));

        // reset while waiting on memory, with a stale response arriving across and after reset
        k = mk_key(32'd900);
        setup_table(64'hFF, -1, k);
        bus.key = k; bus.ctr_in = 2'd1; bus.table_index = 32'd2; bus.table_size = 32'd8;
        @(posedge clk);
        @(negedge clk);
        bus.ctr_in = 0;
        #1;
        check("midrst read issued", KEY_W'(bus.mem_rd_en), KEY_W'(1));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.mem_rsp_valid = 1; bus.mem_rsp_occupied = 1; bus.mem_rsp_key = k;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_values("midrst");
        @(posedge clk);
        @(negedge clk);
        bus.mem_rsp_valid = 0;
        #1;
        check("stale rsp res_valid", KEY_W'(bus.res_valid), KEY_W'(0));
        check("stale rsp res_hit", KEY_W'(bus.res_hit), KEY_W'(0));
        check("stale rsp mem_rd_en", KEY_W'(bus.mem_rd_en), KEY_W'(0));
        check("stale rsp stall", KEY_W'(bus.stall), KEY_W'(0));
        t_keys = 0; t_hits = 0; t_full = 0; t_probes = 0;

        // hit, miss after two probes, hit
        k = mk_key(32'd901);
        setup_table(64'h0, 1, k);
        run_key("seq A", k, 2'd1, 1, 8, 1, 0, 0, o_hit, o_full, o_index, o_n);
        k = mk_key(32'd902);
        setup_table(64'h10, -1, k);
        run_key("seq B", k, 2'd2, 4, 8, 1, 0, 0, o_hit, o_full, o_index, o_n);
        check("seq B miss index", KEY_W'(o_index), KEY_W'(5));
        k = mk_key(32'd903);
        setup_table(64'h0, 7, k);
        run_key("seq C", k, 2'd3, 7, 8, 1, 0, 0, o_hit, o_full, o_index, o_n);
`ifdef HASH_PROBE_STATS_EN
        check("stat_keys seq", KEY_W'(stat_keys), KEY_W'(3));
        check("stat_hits seq", KEY_W'(stat_hits), KEY_W'(2));
        check("stat_full seq", KEY_W'(stat_full), KEY_W'(0));
        check("stat_probes seq", KEY_W'(stat_probes), KEY_W'(4));
`endif

        for (int n = 0; n < 40; n++) begin
            ts  = $urandom_range(1, 40);
            pct = $urandom_range(30, 100);
            k   = mk_key(32'(5000 + n));
            for (int i = 0; i < TMAX; i++) begin
                occ[i]      = ($urandom_range(0, 99) < pct);
                slot_key[i] = mk_key(32'(1000 + $urandom_range(0, 500)));
            end
            if ($urandom_range(0, 1) == 1) begin
                s           = $urandom_range(0, ts - 1);
                occ[s]      = 1'b1;
                slot_key[s] = k;
            end
            run_key($sformatf("rnd%0d", n), k, 2'($urandom_range(1, 3)), $urandom_range(0, ts - 1), ts,
                    $urandom_range(1, 3), $urandom_range(0, 2), $urandom_range(0, 2),
                    o_hit, o_full, o_index, o_n);
        end

`ifdef HASH_PROBE_STATS_EN
        check("stat_keys total", KEY_W'(stat_keys), KEY_W'(t_keys));
        check("stat_hits total", KEY_W'(stat_hits), KEY_W'(t_hits));
        check("stat_full total", KEY_W'(stat_full), KEY_W'(t_full));
        check("stat_probes total", KEY_W'(stat_probes), KEY_W'(t_probes));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
